// File: rtl/axis_id_demux.sv
// AXI-Stream demux: routes each frame to one of M_COUNT lanes by the top tid bits.
// Build option AXIS_ID_DEMUX_DROP_EN: discard frames whose lane index is >= M_COUNT.
module axis_id_demux #(
    parameter int M_COUNT     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = (DATA_WIDTH + 7) / 8,
    parameter int S_ID_WIDTH  = 8,
    parameter int M_ID_WIDTH  = S_ID_WIDTH - $clog2(M_COUNT),
    parameter bit DEST_ENABLE = 0,
    parameter int DEST_WIDTH  = 8,
    parameter bit USER_ENABLE = 1,
    parameter int USER_WIDTH  = 1,
    parameter bit LAST_ENABLE = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,

    input  logic [DATA_WIDTH-1:0]            s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]            s_axis_tkeep,
    input  logic                             s_axis_tvalid,
    output logic                             s_axis_tready,
    input  logic                             s_axis_tlast,
    input  logic [S_ID_WIDTH-1:0]            s_axis_tid,
    input  logic [DEST_WIDTH-1:0]            s_axis_tdest,
    input  logic [USER_WIDTH-1:0]            s_axis_tuser,

    output logic [M_COUNT*DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [M_COUNT*KEEP_WIDTH-1:0]    m_axis_tkeep,
    output logic [M_COUNT-1:0]               m_axis_tvalid,
    input  logic [M_COUNT-1:0]               m_axis_tready,
    output logic [M_COUNT-1:0]               m_axis_tlast,
    output logic [M_COUNT*M_ID_WIDTH-1:0]    m_axis_tid,
    output logic [M_COUNT*DEST_WIDTH-1:0]    m_axis_tdest,
    output logic [M_COUNT*USER_WIDTH-1:0]    m_axis_tuser,

    output logic                             status_drop
);

    localparam int CL = $clog2(M_COUNT);
    localparam int BW = DATA_WIDTH + KEEP_WIDTH + 1 + M_ID_WIDTH
                      + DEST_WIDTH + USER_WIDTH;
    localparam logic [CL:0]   LIM       = M_COUNT[CL:0];
    localparam logic [CL-1:0] LAST_LANE = CL'(M_COUNT - 1);

`ifdef AXIS_ID_DEMUX_DROP_EN
    typedef enum logic [1:0] {IDLE, ACTIVE, DROP} state_t;
`else
    typedef enum logic [1:0] {IDLE, ACTIVE} state_t;
`endif

    state_t state_q, state_d;

    logic [CL-1:0] idx_raw;
    logic [CL-1:0] idx_in;
    logic [CL-1:0] idx_q, idx_d;
    logic [CL-1:0] sel;
    logic          idx_oor;
    logic          beat_last;
    logic          beat_acc;
    logic          drop_path;
    logic [M_COUNT-1:0]     lane_ready;
    logic [(1<<CL)-1:0]     rdy_pad;
    logic [BW-1:0]          beat_in;

    assign idx_raw   = s_axis_tid[S_ID_WIDTH-1 -: CL];
    assign idx_oor   = {1'b0, idx_raw} >= LIM;
    assign beat_last = LAST_ENABLE ? s_axis_tlast : 1'b1;
    assign beat_acc  = s_axis_tvalid && s_axis_tready;

`ifdef AXIS_ID_DEMUX_DROP_EN
    logic alive_q;
    logic drop_q, drop_d;

    // Keeps the drop path from advertising ready while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alive_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            alive_q <= 1'b1;
            drop_q  <= drop_d;
        end
    end

    assign idx_in      = idx_raw;
    assign drop_path   = alive_q && ((state_q == DROP)
                       || ((state_q == IDLE) && idx_oor));
    assign status_drop = drop_q;
`else
    assign idx_in      = idx_oor ? LAST_LANE : idx_raw;
    assign drop_path   = 1'b0;
    assign status_drop = 1'b0;
`endif

    assign sel = (state_q == IDLE) ? idx_in : idx_q;

    // Zero-pad lane readies so an out-of-range index reads not-ready.
    always_comb begin
        rdy_pad = '0;
        rdy_pad[M_COUNT-1:0] = lane_ready;
    end

    assign s_axis_tready = drop_path || rdy_pad[sel];

    assign beat_in = {
        s_axis_tdata,
        KEEP_ENABLE ? s_axis_tkeep : {KEEP_WIDTH{1'b1}},
        beat_last,
        s_axis_tid[M_ID_WIDTH-1:0],
        DEST_ENABLE ? s_axis_tdest : {DEST_WIDTH{1'b0}},
        USER_ENABLE ? s_axis_tuser : {USER_WIDTH{1'b0}}
    };

    // Frame tracking: latch the route on the first beat, release on tlast.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
`ifdef AXIS_ID_DEMUX_DROP_EN
        drop_d  = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (beat_acc) begin
                    idx_d = idx_in;
`ifdef AXIS_ID_DEMUX_DROP_EN
                    drop_d = drop_path && beat_last;
                    if (!beat_last) state_d = drop_path ? DROP : ACTIVE;
`else
                    if (!beat_last) state_d = ACTIVE;
`endif
                end
            end
            ACTIVE: begin
                if (beat_acc && beat_last) state_d = IDLE;
            end
`ifdef AXIS_ID_DEMUX_DROP_EN
            DROP: begin
                if (beat_acc && beat_last) begin
                    state_d = IDLE;
                    drop_d  = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Frame state and latched lane index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    for (genvar i = 0; i < M_COUNT; i++) begin : g_lane
        logic          in_valid;
        logic          ready_q, ready_d;
        logic          m_valid_q, m_valid_d;
        logic          t_valid_q, t_valid_d;
        logic          ld_out, ld_temp, temp_out;
        logic [BW-1:0] m_beat_q, t_beat_q;

        assign in_valid = s_axis_tvalid && !drop_path && (sel == CL'(i));
        assign ready_d  = m_axis_tready[i]
                        || (!t_valid_q && (!m_valid_q || !in_valid));
        assign lane_ready[i] = ready_q;

        // Skid control: fill the output register, spill to temp on stall.
        always_comb begin
            m_valid_d = m_valid_q;
            t_valid_d = t_valid_q;
            ld_out    = 1'b0;
            ld_temp   = 1'b0;
            temp_out  = 1'b0;
            if (ready_q) begin
                if (m_axis_tready[i] || !m_valid_q) begin
                    m_valid_d = in_valid;
                    ld_out    = 1'b1;
                end else begin
                    t_valid_d = in_valid;
                    ld_temp   = 1'b1;
                end
            end else if (m_axis_tready[i]) begin
                m_valid_d = t_valid_q;
                t_valid_d = 1'b0;
                temp_out  = 1'b1;
            end
        end

        // Lane valids and registered ready.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ready_q   <= 1'b0;
                m_valid_q <= 1'b0;
                t_valid_q <= 1'b0;
            end else begin
                ready_q   <= ready_d;
                m_valid_q <= m_valid_d;
                t_valid_q <= t_valid_d;
            end
        end

        // Lane payload registers; valids qualify them, so no reset.
        always_ff @(posedge clk) begin
            if (ld_out) m_beat_q <= beat_in;
            else if (temp_out) m_beat_q <= t_beat_q;
            if (ld_temp) t_beat_q <= beat_in;
        end

        assign m_axis_tvalid[i] = m_valid_q;
        assign {m_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH],
                m_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH],
                m_axis_tlast[i],
                m_axis_tid[i*M_ID_WIDTH +: M_ID_WIDTH],
                m_axis_tdest[i*DEST_WIDTH +: DEST_WIDTH],
                m_axis_tuser[i*USER_WIDTH +: USER_WIDTH]} = m_beat_q;
    end

endmodule

// File: doc/axis_id_demux.md
AXIS_ID_DEMUX -- requirements
Module: axis_id_demux

Interface
REQ-001 The module SHALL have parameter M_COUNT, default 4, meaning number of output ports (2..16).
REQ-002 The module SHALL have parameters DATA_WIDTH (default 8, data bits), KEEP_ENABLE (default DATA_WIDTH>8, propagate tkeep) and KEEP_WIDTH (default (DATA_WIDTH+7)/8, tkeep bits).
REQ-003 The module SHALL have parameters S_ID_WIDTH (default 8, input tid bits) and M_ID_WIDTH (default S_ID_WIDTH-$clog2(M_COUNT), output tid bits).
REQ-004 The module SHALL have parameters DEST_ENABLE/DEST_WIDTH (0/8), USER_ENABLE/USER_WIDTH (1/1) and LAST_ENABLE (1), each propagating or sizing the named sideband.
REQ-005 The module SHALL have ports clk (in, 1, clock) and rst_n (in, 1, reset; one clock, asynchronous, active-low).
REQ-006 The module SHALL have input slave ports s_axis_tdata/tkeep/tvalid/tlast/tid/tdest/tuser (single stream) and output s_axis_tready (1).
REQ-007 The module SHALL have master ports m_axis_tdata/tkeep/tvalid/tlast/tid/tdest/tuser (out, M_COUNT concatenated lanes) and m_axis_tready (in, M_COUNT).
REQ-008 The module SHALL have output status_drop (1), a one-cycle pulse per discarded frame.

Function
REQ-009 Route index SHALL be s_axis_tid[S_ID_WIDTH-1 -: $clog2(M_COUNT)]; m_axis_tid of the selected lane SHALL be s_axis_tid[M_ID_WIDTH-1:0].
REQ-010 A frame-tracking FSM SHALL have states IDLE, ACTIVE and DROP.
REQ-011 In IDLE, the route index SHALL be sampled from the first accepted beat, and the FSM SHALL enter ACTIVE (or DROP if the index is out of range and the macro is defined).
REQ-012 In ACTIVE/DROP, the latched index SHALL be held regardless of tid on later beats, and the FSM SHALL return to IDLE on the accepted beat with tlast=1.
REQ-013 With LAST_ENABLE=0, every beat SHALL be treated as a complete frame.
REQ-014 Each output lane SHALL have an output register plus a one-entry skid (temp) register; latency SHALL be 1 cycle from input accept to m_axis_tvalid, with 1 beat/cycle sustained throughput.
REQ-015 Each lane's internal ready SHALL be registered: ready_early = m_axis_tready[i] OR (temp empty AND (output empty OR no input this cycle)).
REQ-016 s_axis_tready SHALL equal 1 in DROP and otherwise equal the registered ready of the selected lane (combinational index in IDLE, latched index in ACTIVE).
REQ-017 Non-selected lanes SHALL never assert m_axis_tvalid for the current frame; beat order SHALL be preserved per lane, with no loss or duplication.
REQ-018 A tlast beat followed immediately by the next frame's first beat SHALL be accepted in consecutive cycles with no idle cycle.
REQ-019 m_axis_tkeep SHALL be all-ones when KEEP_ENABLE=0; m_axis_tlast SHALL be 1 when LAST_ENABLE=0; disabled tdest/tuser SHALL read 0.

Reset
REQ-020 While rst_n=0, all m_axis_tvalid, temp valids, s_axis_tready and status_drop SHALL be 0 and the FSM SHALL be in IDLE, all asynchronously.
REQ-021 Reset asserted mid-frame SHALL discard the partial frame; after release the first beat SHALL start a new frame.
REQ-022 Data registers SHALL not require reset.

Configuration
REQ-023 With macro AXIS_ID_DEMUX_DROP_EN defined, frames with route index >= M_COUNT SHALL be accepted at full rate, discarded, and SHALL pulse status_drop for one cycle on the tlast beat.
REQ-024 Without AXIS_ID_DEMUX_DROP_EN, out-of-range indices SHALL route to lane M_COUNT-1, the DROP state SHALL not exist, and status_drop SHALL be tied 0.

Verification (M_COUNT=4, S_ID_WIDTH=8, M_ID_WIDTH=6 unless stated)
REQ-025 Frame tid=0x85, data 0x11,0x22,0x33, tlast on beat 3, all ready -> lane 2 outputs the three beats one cycle later with tid=0x05; lanes 0/1/3 tvalid stay 0.
REQ-026 Back-to-back frames to lane 0 then lane 3, no gap -> both accepted in consecutive cycles, each delivered intact to its lane.
REQ-027 m_axis_tready[1]=0 for 5 cycles mid-frame -> s_axis_tready drops within 2 cycles, at most 2 beats buffered, all beats delivered in order after release.
REQ-028 Beat 2 of a lane-0 frame carries tid=0x40 -> beat still delivered on lane 0.
REQ-029 M_COUNT=3, frame tid index 3 -> with macro: no lane valid, s_axis_tready=1, status_drop=1 for exactly one cycle on tlast; without macro: frame appears on lane 2.
REQ-030 rst_n=0 during beat 2 of 4 -> all m_axis_tvalid=0 immediately; after release, new frame tid=0x45 routes to lane 1.
